// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MIPS multiply/divide unit with HI/LO registers; optional MDU_EARLY_TERM_EN
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] acc;      // product, or {remainder, dividend/quotient}
  logic [2*WIDTH-1:0] mcand;    // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0]   mb;       // multiplier (shifted right) or divisor magnitude
  logic               is_div, div0, neg_q, neg_r;

  logic               op_div, op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;  // top bit is the borrow of the trial subtraction
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic               last_step;

  assign op_div    = op[1];
  assign op_signed = ~op[0];
  assign a_neg     = op_signed & operand_a[WIDTH-1];
  assign b_neg     = op_signed & operand_b[WIDTH-1];
  assign a_mag     = a_neg ? -operand_a : operand_a;
  assign b_mag     = b_neg ? -operand_b : operand_b;

  // Remainder is always below the divisor, so the shifted remainder fits WIDTH+1 bits.
  assign div_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, mb};

  assign prod_fix  = neg_q ? -acc : acc;
  assign quot_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  // Decide whether the current RUN step is the final one
  always_comb begin
    last_step = (count == CW'(WIDTH-1));
`ifdef MDU_EARLY_TERM_EN
    if (!is_div && (mb[WIDTH-1:1] == '0)) last_step = 1'b1;
`endif
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (op_div && (operand_b == '0)) ? FIX : RUN;
      RUN:     if (last_step) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register and registered status outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_nx;
      busy        <= (state_nx != IDLE);
      done        <= (state == FIX);
      div_by_zero <= (state == FIX) && div0;
    end
  end

  // Operand capture and one radix-2 step per RUN cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mb     <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          count  <= '0;
          is_div <= op_div;
          div0   <= op_div && (operand_b == '0);
          neg_q  <= a_neg ^ b_neg;
          neg_r  <= a_neg;
          mb     <= b_mag;
          if (op_div) begin
            acc   <= {{WIDTH{1'b0}}, a_mag};
            mcand <= '0;
          end else begin
            acc   <= '0;
            mcand <= {{WIDTH{1'b0}}, a_mag};
          end
        end
        RUN: begin
          count <= count + 1'b1;
          if (is_div) begin
            if (!div_diff[WIDTH]) acc <= {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else                  acc <= {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
          end else begin
            if (mb[0]) acc <= acc + mcand;
            mcand <= {mcand[2*WIDTH-2:0], 1'b0};
            mb    <= mb >> 1;
          end
        end
        default: ;
      endcase
    end
  end

  // HI/LO: sign-corrected result in FIX, MTHI/MTLO only when idle and not starting
  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (state == FIX) begin
      if (!div0) begin
        if (is_div) begin
          hi <= rem_fix;
          lo <= quot_fix;
        end else begin
          {hi, lo} <= prod_fix;
        end
      end
    end else if ((state == IDLE) && !start) begin
      if (hi_we) hi <= wdata;
      if (lo_we) lo <= wdata;
    end
  end
endmodule
